// File: rtl/jtag_host.sv
// rtl/jtag_host.sv - JTAG TAP host that runs RESET, SCAN_IR, SCAN_DR and IDLE commands
// Optional trst output is built only when JTAG_HOST_TRST_EN is defined.
module jtag_host #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
`ifdef JTAG_HOST_TRST_EN
    output logic        trst,
`endif
    input  logic        tdo
);

    localparam logic [1:0] OP_RESET   = 2'b00;
    localparam logic [1:0] OP_SCAN_IR = 2'b01;
    localparam logic [1:0] OP_SCAN_DR = 2'b10;
    localparam logic [1:0] OP_IDLE    = 2'b11;
    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_PRE, S_SHIFT, S_POST, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  len_q, len_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rsp_q, rsp_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  div_q, div_d;
    logic        tck_q, tck_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;
    logic        running;

    // Index of the final TCK within each sequencing state.
    function automatic logic [4:0] last_idx(input state_t s, input logic [1:0] op,
                                            input logic [4:0] len);
        case (s)
            S_INIT:  return 5'd5;
            S_PRE:   return (op == OP_RESET) ? 5'd5 : (op == OP_SCAN_IR) ? 5'd3 : 5'd2;
            S_SHIFT: return len;
            default: return 5'd1;
        endcase
    endfunction

    function automatic state_t next_seq(input state_t s, input logic [1:0] op);
        case (s)
            S_INIT:  return S_IDLE;
            S_PRE:   return (op == OP_RESET) ? S_RESP : S_SHIFT;
            S_SHIFT: return (op == OP_IDLE) ? S_RESP : S_POST;
            default: return S_RESP;
        endcase
    endfunction

    function automatic logic tms_fn(input state_t s, input logic [1:0] op,
                                    input logic [4:0] cnt, input logic [4:0] len);
        case (s)
            S_INIT: return cnt != 5'd5;
            S_PRE: begin
                case (op)
                    OP_RESET:   return cnt != 5'd5;
                    OP_SCAN_IR: return cnt < 5'd2;
                    default:    return cnt == 5'd0;
                endcase
            end
            S_SHIFT: return (op != OP_IDLE) && (cnt == len);
            S_POST:  return cnt == 5'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic tdi_fn(input state_t s, input logic [1:0] op,
                                    input logic [4:0] cnt, input logic [31:0] data);
        return (s == S_SHIFT) && (op != OP_IDLE) && data[cnt];
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        data_d  = data_q;
        rsp_d   = rsp_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        tck_d   = tck_q;
        running = (state_q == S_INIT) || (state_q == S_PRE) ||
                  (state_q == S_SHIFT) || (state_q == S_POST);
        if (state_q == S_IDLE && cmd_valid) begin
            op_d    = cmd_op;
            len_d   = cmd_len;
            data_d  = cmd_data;
            rsp_d   = '0;
            cnt_d   = '0;
            div_d   = '0;
            tck_d   = 1'b0;
            state_d = (cmd_op == OP_IDLE) ? S_SHIFT : S_PRE;
        end else if (state_q == S_RESP) begin
            if (rsp_ready) state_d = S_IDLE;
        end else if (running) begin
            if (div_q != DIV_LAST) begin
                div_d = div_q + 8'd1;
            end else begin
                div_d = '0;
                tck_d = !tck_q;
                if (!tck_q) begin
                    // Rising TCK edge: capture TDO for the current shift bit.
                    if (state_q == S_SHIFT && op_q != OP_IDLE) rsp_d[cnt_q] = tdo;
                end else if (cnt_q == last_idx(state_q, op_q, len_q)) begin
                    cnt_d   = '0;
                    state_d = next_seq(state_q, op_q);
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
        end
        // TMS/TDI follow state/count, which only move on the edge that drives TCK low.
        tms_d = tms_fn(state_d, op_d, cnt_d, len_d);
        tdi_d = tdi_fn(state_d, op_d, cnt_d, data_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            op_q    <= OP_RESET;
            len_q   <= '0;
            data_q  <= '0;
            rsp_q   <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

`ifdef JTAG_HOST_TRST_EN
    logic trst_q, trst_d;

    always_comb begin
        trst_d = (state_d == S_INIT) ||
                 (state_d == S_PRE && op_d == OP_RESET && cnt_d == 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) trst_q <= 1'b1;
        else     trst_q <= trst_d;
    end

    assign trst = trst_q;
`endif

endmodule

// File: tb/tb_jtag_host.sv
// tb/tb_jtag_host.sv - directed vector bench for jtag_host with a behavioural TAP model
`timescale 1ns/1ps
module tb_jtag_host;

    localparam logic [31:0] IDCODE = 32'h1234_5677;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, tck, tms, tdi, tdo;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_data, rsp_data;
    logic        rst2, cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2, tck2, tms2, tdi2, tdo2;
    logic [1:0]  cmd_op2;
    logic [4:0]  cmd_len2;
    logic [31:0] cmd_data2, rsp_data2;
`ifdef JTAG_HOST_TRST_EN
    logic trst, trst2;
`endif

    jtag_host #(.CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .tck(tck), .tms(tms), .tdi(tdi),
`ifdef JTAG_HOST_TRST_EN
        .trst(trst),
`endif
        .tdo(tdo)
    );

    jtag_host #(.CLK_DIV(1)) dut2 (
        .clk(clk), .rst(rst2), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_op(cmd_op2), .cmd_len(cmd_len2), .cmd_data(cmd_data2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2),
        .tck(tck2), .tms(tms2), .tdi(tdi2),
`ifdef JTAG_HOST_TRST_EN
        .trst(trst2),
`endif
        .tdo(tdo2)
    );

    // TAP model: 8-bit IR capturing 0x01, DR always the 32-bit IDCODE register.
    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
                              SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR} tap_t;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:     return m ? TLR   : RTI;
            RTI:     return m ? SELDR : RTI;
            SELDR:   return m ? SELIR : CAPDR;
            CAPDR:   return m ? EX1DR : SHDR;
            SHDR:    return m ? EX1DR : SHDR;
            EX1DR:   return m ? UPDR  : PAUDR;
            PAUDR:   return m ? EX2DR : PAUDR;
            EX2DR:   return m ? UPDR  : SHDR;
            UPDR:    return m ? SELDR : RTI;
            SELIR:   return m ? TLR   : CAPIR;
            CAPIR:   return m ? EX1IR : SHIR;
            SHIR:    return m ? EX1IR : SHIR;
            EX1IR:   return m ? UPIR  : PAUIR;
            PAUIR:   return m ? EX2IR : PAUIR;
            EX2IR:   return m ? UPIR  : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    tap_t        tap = TLR;
    logic [31:0] dr_sr = '0, dr_upd = '0;
    logic [7:0]  ir_sr = '0, ir_reg = '0;
    int          tck_cnt = 0;
    logic        tms_hist [0:4095];

    always @(posedge tck) begin
        tms_hist[tck_cnt[11:0]] <= tms;
        tck_cnt <= tck_cnt + 1;
        case (tap)
            CAPDR:   dr_sr  <= IDCODE;
            SHDR:    dr_sr  <= {tdi, dr_sr[31:1]};
            UPDR:    dr_upd <= dr_sr;
            CAPIR:   ir_sr  <= 8'h01;
            SHIR:    ir_sr  <= {tdi, ir_sr[7:1]};
            UPIR:    ir_reg <= ir_sr;
            default: ;
        endcase
        tap <= tap_next(tap, tms);
    end

    assign tdo  = (tap == SHDR) ? dr_sr[0] : (tap == SHIR) ? ir_sr[0] : 1'b0;
    assign tdo2 = tdi2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tck2_cnt = 0, tck2_last = 0, tck2_prev = 0;
    always @(posedge tck2) begin
        tck2_cnt  <= tck2_cnt + 1;
        tck2_prev <= tck2_last;
        tck2_last <= cyc;
    end

    logic [31:0] rsp2_q [$];
    always @(posedge clk) if (rsp_valid2 && rsp_ready2) rsp2_q.push_back(rsp_data2);

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] get_pat(input int base, input int n);
        logic [63:0] p;
        logic [11:0] idx;
        p = '0;
        for (int i = 0; i < n && i < 64; i++) begin
            idx  = 12'(base + i);
            p[i] = tms_hist[idx];
        end
        return p;
    endfunction

    task automatic wait_ready(output bit ok, output bit saw_rsp);
        ok = 0;
        saw_rsp = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1;
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  len;
        logic [31:0] data;
        int          tcks;
        logic [63:0] tms_pat;
        logic [31:0] rsp;
        bit          chk_dr;
        logic [31:0] dr;
        bit          chk_ir;
        logic [7:0]  ir;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data,
                                input int tcks, input logic [63:0] pat, input logic [31:0] rsp,
                                input bit chk_dr, input logic [31:0] dr,
                                input bit chk_ir, input logic [7:0] ir);
        vec_t v;
        v.op = op; v.len = len; v.data = data; v.tcks = tcks; v.tms_pat = pat; v.rsp = rsp;
        v.chk_dr = chk_dr; v.dr = dr; v.chk_ir = chk_ir; v.ir = ir;
        return v;
    endfunction

    task automatic run_cmd(input vec_t v, input string tag, input int hold);
        bit ok, saw;
        int base;
        bit hold_ok;
        wait_ready(ok, saw);
        check({tag, "_ready"}, 64'(ok), 64'd1);
        base = tck_cnt;
        cmd_valid = 1; cmd_op = v.op; cmd_len = v.len; cmd_data = v.data;
        @(negedge clk);
        cmd_valid = 0; cmd_op = ~v.op; cmd_len = ~v.len; cmd_data = ~v.data;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rsp_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_rsp_valid"}, 64'(ok), 64'd1);
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'(v.rsp));
        check({tag, "_tck_count"}, 64'(tck_cnt - base), 64'(v.tcks));
        check({tag, "_tms_pattern"}, get_pat(base, v.tcks), v.tms_pat);
        check({tag, "_tap_rti"}, 64'(tap), 64'(RTI));
        if (v.chk_dr) check({tag, "_tap_dr"}, 64'(dr_upd), 64'(v.dr));
        if (v.chk_ir) check({tag, "_tap_ir"}, 64'(ir_reg), 64'(v.ir));
        if (hold > 0) begin
            hold_ok = 1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!(rsp_valid && !cmd_ready && !tck && rsp_data == v.rsp)) hold_ok = 0;
            end
            check({tag, "_hold_stable"}, 64'(hold_ok), 64'd1);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check({tag, "_ready_after_rsp"}, {cmd_ready, rsp_valid}, 64'b10);
    endtask

    vec_t vecs [7];

    initial begin
        bit ok, saw;
        int base, tries;

        vecs[0] = mk(2'b10, 5'd31, 32'hA5A5_0F0F, 37, 64'hC_0000_0001, IDCODE, 1, 32'hA5A5_0F0F, 0, 8'h0);
        vecs[1] = mk(2'b01, 5'd7,  32'h0000_0002, 14, 64'h1803, 32'h1, 0, 32'h0, 1, 8'h02);
        vecs[2] = mk(2'b10, 5'd15, 32'h0000_BEEF, 21, 64'hC_0001, 32'h5677, 1, 32'hBEEF_1234, 0, 8'h0);
        vecs[3] = mk(2'b00, 5'd0,  32'hFFFF_FFFF, 6, 64'h1F, 32'h0, 0, 32'h0, 0, 8'h0);
        vecs[4] = mk(2'b11, 5'd3,  32'hFFFF_FFFF, 4, 64'h0, 32'h0, 0, 32'h0, 0, 8'h0);
        vecs[5] = mk(2'b10, 5'd0,  32'h0000_0001, 6, 64'h19, 32'h1, 1, 32'h891A_2B3B, 0, 8'h0);
        vecs[6] = mk(2'b01, 5'd3,  32'h0000_000A, 10, 64'h183, 32'h1, 0, 32'h0, 1, 8'hA0);

        rst = 1; cmd_valid = 0; cmd_op = 0; cmd_len = 0; cmd_data = 0; rsp_ready = 0;
        rst2 = 1; cmd_valid2 = 0; cmd_op2 = 2'b10; cmd_len2 = 0; cmd_data2 = 0; rsp_ready2 = 1;
        repeat (3) @(negedge clk);
        check("rst_tck", 64'(tck), 64'd0);
        check("rst_tms", 64'(tms), 64'd1);
        check("rst_tdi", 64'(tdi), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
`ifdef JTAG_HOST_TRST_EN
        check("rst_trst", 64'(trst), 64'd1);
`endif
        rst = 0; rst2 = 0;

        wait_ready(ok, saw);
        check("init_ready", 64'(ok), 64'd1);
        check("init_no_rsp", 64'(saw), 64'd0);
        check("init_tck_count", 64'(tck_cnt), 64'd6);
        check("init_tms_pattern", get_pat(0, 6), 64'h1F);
        check("init_tap_rti", 64'(tap), 64'(RTI));

        for (int i = 0; i < 7; i++) run_cmd(vecs[i], $sformatf("vec%0d", i), 0);

        run_cmd(vecs[4], "idle_hold", 20);

        // Abort a 32-bit DR scan while shift bit 10 is in progress.
        wait_ready(ok, saw);
        check("abort_ready", 64'(ok), 64'd1);
        base = tck_cnt;
        cmd_valid = 1; cmd_op = 2'b10; cmd_len = 5'd31; cmd_data = 32'hFFFF_0000;
        @(negedge clk);
        cmd_valid = 0;
        tries = 0;
        while (tck_cnt - base < 13 && tries < 1000) begin
            @(negedge clk);
            tries++;
        end
        check("abort_reach_bit10", 64'(tck_cnt - base), 64'd13);
        rst = 1;
        @(negedge clk);
        check("abort_tck_low", 64'(tck), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        rst = 0;
        base = tck_cnt;
        wait_ready(ok, saw);
        check("abort_reinit_ready", 64'(ok), 64'd1);
        check("abort_no_rsp", 64'(saw), 64'd0);
        check("abort_tck_count", 64'(tck_cnt - base), 64'd6);
        check("abort_tms_pattern", get_pat(base, 6), 64'h1F);
        check("abort_tap_rti", 64'(tap), 64'(RTI));
        run_cmd(vecs[0], "post_abort", 0);

        // CLK_DIV=1 instance: back-to-back single-bit DR scans with TDO looped to TDI.
        tries = 0;
        while (!cmd_ready2 && tries < 1000) begin
            @(negedge clk);
            tries++;
        end
        check("b2b_init_ready", 64'(cmd_ready2), 64'd1);
        base = tck2_cnt;
        for (int k = 0; k < 3; k++) begin
            tries = 0;
            while (!cmd_ready2 && tries < 1000) begin
                @(negedge clk);
                tries++;
            end
            cmd_valid2 = 1;
            cmd_data2 = (k == 0) ? 32'h1 : (k == 1) ? 32'h2 : 32'h7;
            @(negedge clk);
            cmd_valid2 = 0;
        end
        tries = 0;
        while (rsp2_q.size() < 3 && tries < 1000) begin
            @(negedge clk);
            tries++;
        end
        check("b2b_rsp_count", 64'(rsp2_q.size()), 64'd3);
        if (rsp2_q.size() == 3) begin
            check("b2b_rsp0", 64'(rsp2_q[0]), 64'd1);
            check("b2b_rsp1", 64'(rsp2_q[1]), 64'd0);
            check("b2b_rsp2", 64'(rsp2_q[2]), 64'd1);
        end
        check("b2b_tck_count", 64'(tck2_cnt - base), 64'd18);
        check("b2b_tck_period", 64'(tck2_last - tck2_prev), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
